multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback over a single shared memory port.
- Drives `alu_op_type` into `alu_control` and sets the ALU operand muxes.
- Resolves branch direction from the ALU comparison result.
- Produces the PC, IR, register-file and memory strobes.

Parameters:
- None. All encodings come from the shared constants package.

Ports:
- clock  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- inst_opcode  in  7  IR[6:0]
- inst_funct3  in  3  IR[14:12]
- alu_result_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  store request
- mem_addr_select  out  1  0=PC, 1=ALU_OUT
- ir_write  out  1  latch the fetched word into IR
- mem_data_write  out  1  latch load data
- alu_out_write  out  1  latch the ALU result into ALU_OUT
- alu_op_type  out  2  CTL_ALU_ADD / CTL_ALU_OP / CTL_ALU_OP_IMM / CTL_ALU_BRANCH
- alu_a_select  out  2  RS1 / PC / ZERO
- alu_b_select  out  1  RS2 / IMM
- reg_write  out  1  register-file write enable
- wb_select  out  2  ALU_OUT / MEM_DATA / PC_PLUS4
- pc_write  out  1  PC update
- next_pc_select  out  2  PC_PLUS4 / PC_TARGET (pc+imm) / PC_JALR ((rs1+imm)&~1)
- illegal_inst  out  1  sticky trap flag
- instr_retired  out  1  one-cycle pulse per completed instruction

Behaviour:
- Reset (sync, reset_n=0 at posedge):
  - state<=FETCH, class<=NONE, illegal_inst<=0.
  - While reset_n=0, every output is forced 0 combinationally.
  - Reset aborts any state, including an outstanding memory wait; no pc_write or retire occurs.
- Outputs: combinational decode of state, registered class, and mem_ready/alu_result_zero. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, mem_addr_select=PC, mem_we=0.
  - mem_ready=1: ir_write=1, go to DECODE. Otherwise stay in FETCH with mem_req held.
- DECODE:
  - Classify inst_opcode into LOAD, STORE, OP, OP_IMM, BRANCH, JAL, JALR, LUI, AUIPC, FENCE.
  - Latch class, go to EXECUTE.
  - Any other opcode (SYSTEM included): illegal_inst<=1, go to HALT.
- EXECUTE, by class:
  - OP: CTL_ALU_OP, a=RS1, b=RS2, alu_out_write=1, go to WB.
  - OP_IMM: CTL_ALU_OP_IMM, a=RS1, b=IMM, alu_out_write=1, go to WB.
  - LUI: CTL_ALU_ADD, a=ZERO, b=IMM, alu_out_write=1, go to WB.
  - AUIPC: CTL_ALU_ADD, a=PC, b=IMM, alu_out_write=1, go to WB.
  - LOAD/STORE: CTL_ALU_ADD, a=RS1, b=IMM, alu_out_write=1, go to MEM.
  - JAL/JALR: no ALU use, go to WB.
  - BRANCH:
    - CTL_ALU_BRANCH, a=RS1, b=RS2.
    - taken = (~alu_result_zero) XOR inst_funct3[0].
    - pc_write=1; next_pc_select = taken ? PC_TARGET : PC_PLUS4.
    - instr_retired=1, go to FETCH.
  - FENCE: pc_write=1 (PC_PLUS4), instr_retired=1, go to FETCH.
- MEM:
  - mem_req=1, mem_addr_select=ALU_OUT, mem_we=(class==STORE).
  - Stay while mem_ready=0.
  - On ready, LOAD: mem_data_write=1, go to WB.
  - On ready, STORE: pc_write=1 (PC_PLUS4), instr_retired=1, go to FETCH.
- WB:
  - reg_write=1 and instr_retired=1 for every class that reaches WB.
  - wb_select: MEM_DATA for LOAD; PC_PLUS4 for JAL/JALR; ALU_OUT otherwise.
  - pc_write=1. next_pc_select: PC_TARGET for JAL, PC_JALR for JALR, PC_PLUS4 otherwise.
  - Go to FETCH.
- HALT: all strobes 0, illegal_inst=1; stays until reset.
- Latency with zero-wait memory (FETCH sees mem_ready in its first cycle):
  - Branch/FENCE: 3 cycles.
  - OP/OP_IMM/LUI/AUIPC/JAL/JALR/STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- Invariants: mem_req and mem_we are never asserted outside FETCH/MEM; instr_retired pulses exactly once per instruction.

Decomposition:
- Package ctl_pkg holds:
  - state enum {FETCH, DECODE, EXECUTE, MEM, WB, HALT}
  - instruction-class enum
  - OPCODE_* constants
  - select encodings (ALU_A_*, ALU_B_*, WB_*, PC_*, MEM_ADDR_*)
- CTL_ALU_* stay in the existing constants package.
- One sub-module: inst_classifier, a combinational map opcode -> {class, legal}.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles mid-run -> all outputs 0. First cycle after release: state FETCH, mem_req=1, mem_addr_select=PC.
2. ADD (opcode 0110011), mem_ready=1:
   - States F, D, E, WB in 4 cycles.
   - EXECUTE: alu_op_type=CTL_ALU_OP, a=RS1, b=RS2.
   - WB: reg_write=1, wb_select=ALU_OUT, pc_write=1 with PC_PLUS4, instr_retired=1 once.
3. LW with mem_ready low for 3 cycles in MEM:
   - mem_req=1, mem_we=0, mem_addr_select=ALU_OUT held 4 cycles.
   - Then mem_data_write=1, then WB with wb_select=MEM_DATA; 8 cycles total.
4. Branches:
   - BNE (funct3=001), alu_result_zero=1 -> next_pc_select=PC_TARGET, retire in cycle 3.
   - BEQ (000), alu_result_zero=1 -> PC_PLUS4.
   - BGE (101), alu_result_zero=0 -> PC_PLUS4.
5. Illegal opcode 0000000:
   - After DECODE: HALT, illegal_inst=1; mem_req, pc_write and instr_retired stay 0 for 20 cycles.
   - Then reset_n=0 -> illegal_inst=0, fetch resumes.
6. SW with mem_ready=0, reset_n=0 asserted in MEM:
   - Next cycle: state FETCH, mem_we=0.
   - No pc_write and no instr_retired for that store.

Source files
------------

// File: rtl/core_const_pkg.sv
// Core-wide constants that are shared between the control FSM and the datapath.
// The ALU control decoder consumes the operation classes defined here.
package core_const_pkg;

  localparam logic [1:0] CTL_ALU_ADD    = 2'd0;
  localparam logic [1:0] CTL_ALU_OP     = 2'd1;
  localparam logic [1:0] CTL_ALU_OP_IMM = 2'd2;
  localparam logic [1:0] CTL_ALU_BRANCH = 2'd3;

endpackage

// File: rtl/ctl_pkg.sv
// Types and encodings that are local to the multi-cycle control FSM.
// This covers FSM states, instruction classes, RV32I major opcodes and datapath select values.
package ctl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LOAD   = 4'd1,
    CLS_STORE  = 4'd2,
    CLS_OP     = 4'd3,
    CLS_OP_IMM = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9,
    CLS_FENCE  = 4'd10
  } inst_class_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic [1:0] WB_ALU_OUT  = 2'd0;
  localparam logic [1:0] WB_MEM_DATA = 2'd1;
  localparam logic [1:0] WB_PC_PLUS4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic MEM_ADDR_PC      = 1'b0;
  localparam logic MEM_ADDR_ALU_OUT = 1'b1;

endpackage

// File: rtl/inst_classifier.sv
// This block is a pure combinational map from a major opcode to an instruction class plus a legal flag.
// It has zero latency and no flow control.
module inst_classifier
  import ctl_pkg::*;
(
  input  logic [6:0]  opcode,
  output inst_class_t inst_class,
  output logic        legal
);

  always_comb begin
    inst_class = CLS_NONE;
    legal      = 1'b1;
    case (opcode)
      OPCODE_LOAD:   inst_class = CLS_LOAD;
      OPCODE_STORE:  inst_class = CLS_STORE;
      OPCODE_OP:     inst_class = CLS_OP;
      OPCODE_OP_IMM: inst_class = CLS_OP_IMM;
      OPCODE_BRANCH: inst_class = CLS_BRANCH;
      OPCODE_JAL:    inst_class = CLS_JAL;
      OPCODE_JALR:   inst_class = CLS_JALR;
      OPCODE_LUI:    inst_class = CLS_LUI;
      OPCODE_AUIPC:  inst_class = CLS_AUIPC;
      OPCODE_FENCE:  inst_class = CLS_FENCE;
      default:       legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// This is the main control FSM for the multi-cycle RV32I core. It takes 3 to 5 cycles per instruction with zero-wait memory.
// The FSM holds in FETCH and MEM while mem_ready is low, with mem_req kept asserted.
module multicycle_control
  import core_const_pkg::*;
  import ctl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] inst_opcode,
  input  logic [2:0] inst_funct3,
  input  logic       alu_result_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_select,
  output logic       ir_write,
  output logic       mem_data_write,
  output logic       alu_out_write,
  output logic [1:0] alu_op_type,
  output logic [1:0] alu_a_select,
  output logic       alu_b_select,
  output logic       reg_write,
  output logic [1:0] wb_select,
  output logic       pc_write,
  output logic [1:0] next_pc_select,
  output logic       illegal_inst,
  output logic       instr_retired
);

  state_t      state_q, state_d;
  inst_class_t class_q;
  inst_class_t dec_class;
  logic        dec_legal;
  logic        illegal_q;
  logic        branch_taken;
  logic        unused_funct3;

  inst_classifier u_classifier (
    .opcode     (inst_opcode),
    .inst_class (dec_class),
    .legal      (dec_legal)
  );

  // funct3[0] inverts the sense of the compare (BEQ/BNE, BLT/BGE, BLTU/BGEU).
  assign branch_taken  = (~alu_result_zero) ^ inst_funct3[0];
  assign unused_funct3 = ^inst_funct3[2:1];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      class_q   <= CLS_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        class_q <= dec_class;
        if (!dec_legal) illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:  state_d = dec_legal ? ST_EXECUTE : ST_HALT;
      ST_EXECUTE: begin
        case (class_q)
          CLS_BRANCH, CLS_FENCE: state_d = ST_FETCH;
          CLS_LOAD, CLS_STORE:   state_d = ST_MEM;
          CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC,
          CLS_JAL, CLS_JALR:     state_d = ST_WB;
          default:               state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr_select = MEM_ADDR_PC;
    ir_write        = 1'b0;
    mem_data_write  = 1'b0;
    alu_out_write   = 1'b0;
    alu_op_type     = CTL_ALU_ADD;
    alu_a_select    = ALU_A_RS1;
    alu_b_select    = ALU_B_RS2;
    reg_write       = 1'b0;
    wb_select       = WB_ALU_OUT;
    pc_write        = 1'b0;
    next_pc_select  = PC_PLUS4;
    illegal_inst    = 1'b0;
    instr_retired   = 1'b0;
    // Every output is held at zero while reset is low, whatever the current state is.
    if (reset_n) begin
      illegal_inst = illegal_q;
      case (state_q)
        ST_FETCH: begin
          mem_req         = 1'b1;
          mem_addr_select = MEM_ADDR_PC;
          ir_write        = mem_ready;
        end
        ST_EXECUTE: begin
          case (class_q)
            CLS_OP: begin
              alu_op_type   = CTL_ALU_OP;
              alu_a_select  = ALU_A_RS1;
              alu_b_select  = ALU_B_RS2;
              alu_out_write = 1'b1;
            end
            CLS_OP_IMM: begin
              alu_op_type   = CTL_ALU_OP_IMM;
              alu_a_select  = ALU_A_RS1;
              alu_b_select  = ALU_B_IMM;
              alu_out_write = 1'b1;
            end
            CLS_LUI: begin
              alu_op_type   = CTL_ALU_ADD;
              alu_a_select  = ALU_A_ZERO;
              alu_b_select  = ALU_B_IMM;
              alu_out_write = 1'b1;
            end
            CLS_AUIPC: begin
              alu_op_type   = CTL_ALU_ADD;
              alu_a_select  = ALU_A_PC;
              alu_b_select  = ALU_B_IMM;
              alu_out_write = 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_op_type   = CTL_ALU_ADD;
              alu_a_select  = ALU_A_RS1;
              alu_b_select  = ALU_B_IMM;
              alu_out_write = 1'b1;
            end
            CLS_BRANCH: begin
              alu_op_type    = CTL_ALU_BRANCH;
              alu_a_select   = ALU_A_RS1;
              alu_b_select   = ALU_B_RS2;
              pc_write       = 1'b1;
              next_pc_select = branch_taken ? PC_TARGET : PC_PLUS4;
              instr_retired  = 1'b1;
            end
            CLS_FENCE: begin
              pc_write       = 1'b1;
              next_pc_select = PC_PLUS4;
              instr_retired  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req         = 1'b1;
          mem_addr_select = MEM_ADDR_ALU_OUT;
          mem_we          = (class_q == CLS_STORE);
          if (mem_ready) begin
            if (class_q == CLS_LOAD) begin
              mem_data_write = 1'b1;
            end else begin
              pc_write       = 1'b1;
              next_pc_select = PC_PLUS4;
              instr_retired  = 1'b1;
            end
          end
        end
        ST_WB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          pc_write      = 1'b1;
          case (class_q)
            CLS_LOAD: wb_select = WB_MEM_DATA;
            CLS_JAL: begin
              wb_select      = WB_PC_PLUS4;
              next_pc_select = PC_TARGET;
            end
            CLS_JALR: begin
              wb_select      = WB_PC_PLUS4;
              next_pc_select = PC_JALR;
            end
            default: begin
              wb_select      = WB_ALU_OUT;
              next_pc_select = PC_PLUS4;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
